arbitro_wrr: RTL and testbench

- Weighted round-robin scheduler for the four class FIFOs (fifo0..fifo3) loaded by the class demux.
- Pops one word per cycle from the granted class FIFO and forwards it to one of four destination FIFOs, selected by dest bits [9:8].
- A pop is only issued when no destination FIFO asserts almost_full.
- Owns the "who reads next" decision between the class stage and the destination stage.

---
 rtl/arbitro_wrr_if.sv | 25 ++
 rtl/arbitro_wrr.sv | 141 ++++++++++++++
 tb/tb_arbitro_wrr.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_wrr_if.sv
// Bus between the WRR scheduler, the four class FIFOs it reads and the
// four destination FIFOs it writes.
interface arbitro_wrr_if #(
  parameter int TAMANO_DATOS = 12
);
  logic [3:0]              empty;
  logic [TAMANO_DATOS-1:0] data_vc0;
  logic [TAMANO_DATOS-1:0] data_vc1;
  logic [TAMANO_DATOS-1:0] data_vc2;
  logic [TAMANO_DATOS-1:0] data_vc3;
  logic [3:0]              almost_full_dest;
  logic [3:0]              pop;
  logic [3:0]              push_dest;
  logic [TAMANO_DATOS-1:0] data_out;

  modport master (
    input  empty, data_vc0, data_vc1, data_vc2, data_vc3, almost_full_dest,
    output pop, push_dest, data_out
  );

  modport slave (
    output empty, data_vc0, data_vc1, data_vc2, data_vc3, almost_full_dest,
    input  pop, push_dest, data_out
  );
endinterface

// File: rtl/arbitro_wrr.sv
// Weighted round-robin scheduler: pops the granted class FIFO and forwards
// each word, two cycles later, to the destination FIFO named by bits [9:8].
module arbitro_wrr #(
  parameter int         TAMANO_DATOS = 12,
  parameter logic [2:0] PESO0        = 3'd4,
  parameter logic [2:0] PESO1        = 3'd2,
  parameter logic [2:0] PESO2        = 3'd1,
  parameter logic [2:0] PESO3        = 3'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  arbitro_wrr_if.master bus,
  output logic [1:0]   estado,
  output logic         idle
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_PAUSE  = 2'b10
  } estado_t;

  typedef logic [TAMANO_DATOS-1:0] word_t;

  estado_t    estado_q, estado_d;
  logic [1:0] cur_q, cur_d;
  logic [2:0] cred_q, cred_d;
  logic       vld1_q, vld1_d;
  logic [1:0] cls1_q, cls1_d;
  logic [3:0] push_q, push_d;
  word_t      data_q, data_d;

  word_t      vc [4];
  word_t      word_in;
  logic [3:0] pop_c;
  logic       any_af;
  logic       sched;
  logic [1:0] nxt_cls;
  logic [1:0] cand;
  logic       found;

  // A programmed weight of 0 still grants one pop so no class starves.
  function automatic logic [2:0] peso_de(input logic [1:0] c);
    logic [2:0] p;
    case (c)
      2'd0:    p = PESO0;
      2'd1:    p = PESO1;
      2'd2:    p = PESO2;
      default: p = PESO3;
    endcase
    return (p == 3'd0) ? 3'd1 : p;
  endfunction

  assign vc[0]  = bus.data_vc0;
  assign vc[1]  = bus.data_vc1;
  assign vc[2]  = bus.data_vc2;
  assign vc[3]  = bus.data_vc3;
  assign any_af = |bus.almost_full_dest;
  assign sched  = (estado_q == ST_ACTIVE) & init & ~any_af;

  // First non-empty class after cur, wrapping back to cur itself.
  always_comb begin : next_class
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nxt_cls = cur_q + 2'd1;
    found   = 1'b0;
    cand    = cur_q;
    for (int k = 1; k <= 4; k++) begin
      cand = cur_q + 2'(k);
      if (!found && !bus.empty[cand]) begin
        nxt_cls = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin : pop_gen
    pop_c = '0;
    if (sched && !bus.empty[cur_q]) pop_c[cur_q] = 1'b1;
  end

  always_comb begin : next_state
    estado_d = estado_q;
    cur_d    = cur_q;
    cred_d   = cred_q;

    case (estado_q)
      ST_IDLE:   if (init) estado_d = ST_ACTIVE;
      ST_ACTIVE: if (!init) estado_d = ST_IDLE;
                 else if (any_af) estado_d = ST_PAUSE;
      ST_PAUSE:  if (!init) estado_d = ST_IDLE;
                 else if (!any_af) estado_d = ST_ACTIVE;
      default:   estado_d = ST_IDLE;
    endcase

    // Quota spent or granted class empty: hand the turn to the next class.
    if (sched) begin
      if ((|pop_c) && (cred_q > 3'd1)) begin
        cred_d = cred_q - 3'd1;
      end else begin
        cur_d  = nxt_cls;
        cred_d = peso_de(nxt_cls);
      end
    end

    // Stage 1 remembers which FIFO was read; stage 2 captures its output.
    vld1_d  = |pop_c;
    cls1_d  = cur_q;
    word_in = vc[cls1_q];
    push_d  = vld1_q ? (4'b0001 << word_in[9:8]) : 4'b0000;
    data_d  = vld1_q ? word_in : data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= ST_IDLE;
      cur_q    <= 2'd0;
      cred_q   <= peso_de(2'd0);
      vld1_q   <= 1'b0;
      cls1_q   <= 2'd0;
      push_q   <= 4'b0000;
      data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      estado_q <= estado_d;
      cur_q    <= cur_d;
      cred_q   <= cred_d;
      vld1_q   <= vld1_d;
      cls1_q   <= cls1_d;
      push_q   <= push_d;
      data_q   <= data_d;
    end
  end

  assign bus.pop       = pop_c;
  assign bus.push_dest = push_q;
  assign bus.data_out  = data_q;
  assign estado        = estado_q;
  assign idle          = (estado_q == ST_IDLE) & ~vld1_q & ~(|push_q);

endmodule

// File: tb/tb_arbitro_wrr.sv
// Randomized bench for arbitro_wrr: a queue-based model of the class FIFOs and
// the WRR rules predicts grants; a scoreboard checks every destination push.
module tb_arbitro_wrr;

  localparam int         TD = 12;
  localparam logic [2:0] P0 = 3'd4;
  localparam logic [2:0] P1 = 3'd2;
  localparam logic [2:0] P2 = 3'd1;
  localparam logic [2:0] P3 = 3'd0;  // zero weight must behave as one

  typedef logic [TD-1:0] word_t;
  typedef struct {
    word_t w;
    int    due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic [1:0] estado;
  logic       idle;

  arbitro_wrr_if #(.TAMANO_DATOS(TD)) bus_if ();

  arbitro_wrr #(
    .TAMANO_DATOS(TD), .PESO0(P0), .PESO1(P1), .PESO2(P2), .PESO3(P3)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .bus(bus_if),
    .estado(estado), .idle(idle)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  word_t q0[$], q1[$], q2[$], q3[$];
  exp_t  sb[$];
  logic [3:0] pop_seen = 4'b0;
  logic [3:0] af_val = 4'b0;
  int    p_init = 0, p_af = 0, p_refill = 0, fill_n = 0;
  int    last_push_cyc = -10;
  word_t last_word = '0;
  int    m_state = 0, m_cur = 0, m_cred = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic int quota(input int c);
    int p;
    p = (c == 0) ? int'(P0) : (c == 1) ? int'(P1) : (c == 2) ? int'(P2) : int'(P3);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic int qsize(input int c);
    case (c)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic qpush(input int c, input word_t w);
    case (c)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  task automatic qpop(input int c, output word_t w);
    case (c)
      0: w = q0.pop_front();
      1: w = q1.pop_front();
      2: w = q2.pop_front();
      default: w = q3.pop_front();
    endcase
  endtask

  task automatic set_vc(input int c, input word_t w);
    case (c)
      0: bus_if.data_vc0 = w;
      1: bus_if.data_vc1 = w;
      2: bus_if.data_vc2 = w;
      default: bus_if.data_vc3 = w;
    endcase
  endtask

  function automatic word_t mk_word(input int c);
    word_t w;
    w = word_t'($urandom);
    w[11:10] = 2'(c);
    return w;
  endfunction

  task automatic refresh_flags();
    for (int c = 0; c < 4; c++) bus_if.empty[c] = (qsize(c) == 0);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cur   = 0;
    m_cred  = quota(0);
  endtask

  // What the next clock edge does to the scheduler, given current inputs.
  task automatic model_advance();
    bit sched;
    int nxt;
    sched = (m_state == 1) && init && (bus_if.almost_full_dest == 4'b0);
    if (sched) begin
      if (!bus_if.empty[m_cur] && m_cred > 1) begin
        m_cred--;
      end else begin
        nxt = (m_cur + 1) % 4;
        for (int k = 4; k >= 1; k--)
          if (!bus_if.empty[(m_cur + k) % 4]) nxt = (m_cur + k) % 4;
        m_cur  = nxt;
        m_cred = quota(nxt);
      end
    end
    case (m_state)
      0: if (init) m_state = 1;
      1: if (!init) m_state = 0; else if (bus_if.almost_full_dest != 4'b0) m_state = 2;
      default: if (!init) m_state = 0; else if (bus_if.almost_full_dest == 4'b0) m_state = 1;
    endcase
  endtask

  task automatic model_check();
    logic [3:0] exp_pop;
    bit idle_exp;
    exp_pop = 4'b0;
    if (m_state == 1 && init && bus_if.almost_full_dest == 4'b0 && !bus_if.empty[m_cur])
      exp_pop[m_cur] = 1'b1;
    idle_exp = (m_state == 0) && (sb.size() == 0) && (last_push_cyc != cyc);
    check("pop", 32'(bus_if.pop), 32'(exp_pop));
    check("estado", 32'(estado), 32'(m_state));
    check("idle", 32'(idle), 32'(idle_exp));
    pop_seen = bus_if.pop;
    model_advance();
  endtask

  // One clock: apply last cycle's pop to the FIFO model, new stimulus, then check.
  task automatic step();
    word_t w;
    int    c;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i]) begin
        check("pop_nonempty", 32'(qsize(i) != 0), 32'd1);
        if (qsize(i) != 0) begin
          qpop(i, w);
          set_vc(i, w);
          sb.push_back('{w: w, due: cyc + 1});
        end
      end
    end
    pop_seen = 4'b0;
    for (int i = 0; i < fill_n; i++)
      for (int k = 0; k < 4; k++) qpush(k, mk_word(k));
    fill_n = 0;
    if (int'($urandom_range(99)) < p_refill) begin
      c = int'($urandom_range(3));
      if (qsize(c) < 8) qpush(c, mk_word(c));
    end
    init = (int'($urandom_range(99)) < p_init);
    if (p_af > 0)
      bus_if.almost_full_dest = (int'($urandom_range(99)) < p_af) ? 4'(1 << $urandom_range(3)) : 4'b0;
    else
      bus_if.almost_full_dest = af_val;
    refresh_flags();
    @(negedge clk);
    model_check();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Scoreboard monitor: every push must match the oldest predicted word.
  exp_t e;
  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      if (bus_if.push_dest != 4'b0) begin
        if (sb.size() == 0) begin
          check("push_unexpected", 32'(bus_if.push_dest), 32'd0);
        end else begin
          e = sb.pop_front();
          check("push_cycle", 32'(cyc), 32'(e.due));
          check("push_dest", 32'(bus_if.push_dest), 32'(4'b0001 << e.w[9:8]));
          check("data_out", 32'(bus_if.data_out), 32'(e.w));
          last_word     = e.w;
          last_push_cyc = cyc;
        end
      end else begin
        check("data_out_hold", 32'(bus_if.data_out), 32'(last_word));
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check("push_dest_missing", 32'(bus_if.push_dest), 32'(4'b0001 << e.w[9:8]));
        end
      end
    end
  end

  initial begin
    bus_if.empty            = 4'b1111;
    bus_if.data_vc0         = '0;
    bus_if.data_vc1         = '0;
    bus_if.data_vc2         = '0;
    bus_if.data_vc3         = '0;
    bus_if.almost_full_dest = 4'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pop", 32'(bus_if.pop), 32'd0);
    check("rst_push", 32'(bus_if.push_dest), 32'd0);
    check("rst_data", 32'(bus_if.data_out), 32'd0);
    check("rst_estado", 32'(estado), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    reset = 1'b1;
    model_reset();
    model_advance();

    // Full FIFOs, no backpressure: 0,0,0,0,1,1,2,3,... and A5C routed to dest 2.
    qpush(2, 12'hA5C);
    fill_n = 8;
    p_init = 100;
    run(24);

    // Backpressure pause and resume with the remaining quota.
    fill_n = 4;
    run(3);
    af_val = 4'b1000;
    run(3);
    af_val = 4'b0000;
    run(6);

    // init drops after two class-0 pops, then resumes.
    fill_n = 6;
    for (int i = 0; i < 200 && !(m_cur == 0 && m_cred == 2 && pop_seen == 4'b0001); i++) step();
    p_init = 0;
    run(5);
    p_init = 100;
    run(10);

    // Random traffic, init toggling and almost_full bursts.
    p_init   = 90;
    p_af     = 15;
    p_refill = 60;
    run(3000);

    // Asynchronous reset while class 1 is being popped.
    p_af     = 0;
    af_val   = 4'b0;
    p_init   = 100;
    p_refill = 0;
    fill_n   = 8;
    for (int i = 0; i < 200 && pop_seen != 4'b0010; i++) step();
    if (pop_seen != 4'b0010) check("reach_pop1", 32'(pop_seen), 32'h2);
    #1 reset = 1'b0;
    #1;
    check("midrst_pop", 32'(bus_if.pop), 32'd0);
    check("midrst_push", 32'(bus_if.push_dest), 32'd0);
    check("midrst_estado", 32'(estado), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    model_reset();
    sb.delete();
    pop_seen      = 4'b0;
    last_word     = '0;
    last_push_cyc = -10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_advance();
    run(12);

    // Drain: everything issued must have been pushed.
    p_init = 0;
    run(6);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
